// File: rtl/uart_crc_receiver_pkg.sv
// Shared definitions for the CRC-8 UART link: CRC constants, the bit-timing derivation and
// the receiver state encoding.
package uart_crc_receiver_pkg;

  localparam logic [7:0]  CRC8_POLY     = 8'h07;
  localparam logic [7:0]  CRC8_INIT     = 8'h00;
  localparam int unsigned BAUD_RATE_DEF = 9600;
  localparam int unsigned CLK_FREQ_DEF  = 50000000;
  localparam int unsigned CNT_W         = 13;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StStart2,
    StData,
    StCrc,
    StStop,
    StBreak
  } rx_state_e;

  function automatic int unsigned bit_ticks(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned half_ticks(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
    return bit_ticks(clk_freq, baud_rate) / 2;
  endfunction

  // One byte, MSB first, no reflection and no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_crc_receiver.sv
// CRC-8 UART frame receiver: recovers data and CRC bytes, rechecks the CRC and reports
// start/stop framing faults with a one-cycle valid pulse.
module uart_crc_receiver
  import uart_crc_receiver_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = BAUD_RATE_DEF,
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int unsigned START_BITS = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_in,
  output logic [7:0] o_data_out,
  output logic [7:0] o_crc_out,
  output logic       o_rx_valid,
  output logic       o_crc_error,
  output logic       o_frame_error,
  output logic       o_rx_busy
);

  localparam int unsigned    BitTicks  = bit_ticks(CLK_FREQ, BAUD_RATE);
  localparam int unsigned    HalfTicks = half_ticks(CLK_FREQ, BAUD_RATE);
  localparam logic [CNT_W-1:0] TickFull = CNT_W'(BitTicks - 1);
  localparam logic [CNT_W-1:0] TickHalf = CNT_W'(HalfTicks - 1);

  logic             w_rx_s;
  rx_state_e        r_state;
  rx_state_e        w_state_next;
  logic             w_tick;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_data_sr;
  logic [7:0]       r_crc_sr;
  logic             r_fe_pend;
  logic [7:0]       w_crc_calc;

  logic [7:0]       r_data_out;
  logic [7:0]       r_crc_out;
  logic             r_rx_valid;
  logic             r_crc_error;
  logic             r_frame_error;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx_in),
    .o_q     (w_rx_s)
  );

  assign w_crc_calc = crc8_byte(CRC8_INIT, r_data_sr);

  always_comb begin
    w_state_next = r_state;
    w_tick       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_rx_s) w_state_next = StStart;
      end
      // Half-bit check rejects short glitches and puts later samples mid-bit.
      StStart: begin
        if (r_cnt == TickHalf) begin
          w_tick = 1'b1;
          if (w_rx_s)               w_state_next = StIdle;
          else if (START_BITS == 2) w_state_next = StStart2;
          else                      w_state_next = StData;
        end
      end
      StStart2: begin
        if (r_cnt == TickFull) begin
          w_tick       = 1'b1;
          w_state_next = StData;
        end
      end
      StData: begin
        if (r_cnt == TickFull) begin
          w_tick = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_next = StCrc;
        end
      end
      StCrc: begin
        if (r_cnt == TickFull) begin
          w_tick = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_next = StStop;
        end
      end
      StStop: begin
        if (r_cnt == TickFull) begin
          w_tick       = 1'b1;
          w_state_next = w_rx_s ? StIdle : StBreak;
        end
      end
      StBreak: begin
        if (w_rx_s) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_data_sr <= '0;
      r_crc_sr  <= '0;
      r_fe_pend <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_state_next != r_state || w_tick || r_state == StIdle || r_state == StBreak) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == StIdle && !w_rx_s) begin
        r_fe_pend <= 1'b0;
        r_bit_cnt <= '0;
      end

      if (w_tick) begin
        unique case (r_state)
          StStart2: if (w_rx_s) r_fe_pend <= 1'b1;
          StData: begin
            r_data_sr <= {w_rx_s, r_data_sr[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          StCrc: begin
            r_crc_sr  <= {w_rx_s, r_crc_sr[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Results register on the stop-sample edge, so rx_valid shows one clock after that sample.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data_out    <= '0;
      r_crc_out     <= '0;
      r_rx_valid    <= 1'b0;
      r_crc_error   <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_state == StStop && w_tick) begin
        r_data_out    <= r_data_sr;
        r_crc_out     <= r_crc_sr;
        r_rx_valid    <= 1'b1;
        r_crc_error   <= (w_crc_calc != r_crc_sr);
        r_frame_error <= r_fe_pend | ~w_rx_s;
      end
    end
  end

  assign o_data_out    = r_data_out;
  assign o_crc_out     = r_crc_out;
  assign o_rx_valid    = r_rx_valid;
  assign o_crc_error   = r_crc_error;
  assign o_frame_error = r_frame_error;
  assign o_rx_busy     = (r_state != StIdle) && (r_state != StStart);

endmodule
